secuenciador_orden_servo: RTL

//  Upstream stage of the servo PWM block: accepts 3-bit servo commands (orden) from the

---
 rtl/servo_pkg.sv | 18 +
 rtl/fifo_orden.sv | 59 +++++
 rtl/secuenciador_orden_servo.sv | 113 +++++++++++
 3 files changed

// File: rtl/servo_pkg.sv
// Shared definitions for the servo command sequencer: command width, rest code,
// FSM state encoding and the FIFO count width helper.
package servo_pkg;

    localparam int                 ORDEN_W      = 3;
    localparam logic [ORDEN_W-1:0] ORDEN_REPOSO = 3'd0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } estado_e;

    // A count must reach DEPTH itself, hence one bit more than the address.
    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_orden.sv
// Synchronous command FIFO. Pointers carry one extra MSB so that full and empty
// are told apart when the address bits match.
module fifo_orden
    import servo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ORDEN_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic                      push_i,
    input  logic [WIDTH-1:0]          data_i,
    input  logic                      pop_i,
    output logic [WIDTH-1:0]          data_o,
    output logic [count_w(DEPTH)-1:0] count_o,
    output logic                      full_o,
    output logic                      empty_o
);

    localparam int            AW      = $clog2(DEPTH);
    localparam int            CW      = count_w(DEPTH);
    localparam logic [CW-1:0] PTR_ONE = CW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    wr_ptr_q;
    logic [CW-1:0]    rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_push = push_i & ~full_o  & ~flush_i;
    assign do_pop  = pop_i  & ~empty_o & ~flush_i;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // NOTE: the storage array is deliberately not reset; validity is defined by the
    // pointers alone, and leaving it out of reset keeps it a plain register file/RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/secuenciador_orden_servo.sv
// Servo command sequencer: queues commands and applies each one on the registered
// orden output for a fixed dwell time, back-to-back when more are waiting.
module secuenciador_orden_servo
    import servo_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int DWELL_CYCLES = 50_000_000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [ORDEN_W-1:0]             cmd_orden,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           flush,
    output logic [ORDEN_W-1:0]             orden,
    output logic                           busy,
    output logic [count_w(FIFO_DEPTH)-1:0] fifo_count,
    output logic                           overflow
);

    localparam int               CNT_W      = $clog2(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    estado_e            state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ORDEN_W-1:0] orden_q, orden_d;
    logic               overflow_q, overflow_d;

    logic               push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ORDEN_W-1:0] fifo_head;

    // Ready depends only on the registered fill level, so a pop in the same cycle
    // never opens room for a push into a full queue.
    assign cmd_ready = ~fifo_full & ~flush;
    assign push      = cmd_valid & cmd_ready;

    fifo_orden #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ORDEN_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .flush_i (flush),
        .push_i  (push),
        .data_i  (cmd_orden),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            orden_q    <= ORDEN_REPOSO;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            orden_q    <= orden_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: every signal driven here gets a default before any branch, which rules out
    // latches; combinational blocks use blocking '=', clocked blocks use '<='.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        orden_d    = orden_q;
        fifo_pop   = 1'b0;
        overflow_d = overflow_q | (cmd_valid & ~cmd_ready);

        if (flush) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            overflow_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        orden_d  = fifo_head;
                        cnt_d    = CNT_RELOAD;
                        state_d  = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        orden_d  = fifo_head;
                        cnt_d    = CNT_RELOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign orden    = orden_q;
    assign busy     = (state_q == ST_HOLD);
    assign overflow = overflow_q;

endmodule
